// File: rtl/cr16_alu_arbiter.sv
// ============================================================================
// Module   : cr16_alu / cr16_alu_arbiter
// Purpose  : Combinational CR16 ALU core plus a two-requester round-robin
//            front end that time-shares it with registered results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cr16_alu #(
  parameter int P_WIDTH = 16
) (
  input  logic               I_ENABLE,
  input  logic [4:0]         I_OPCODE,
  input  logic [P_WIDTH-1:0] I_A,
  input  logic [P_WIDTH-1:0] I_B,
  output logic [P_WIDTH-1:0] O_C,
  output logic [4:0]         O_STATUS
);

  localparam logic [4:0] c_OP_ADD = 5'h00;
  localparam logic [4:0] c_OP_SUB = 5'h01;
  localparam logic [4:0] c_OP_AND = 5'h02;
  localparam logic [4:0] c_OP_OR  = 5'h03;
  localparam logic [4:0] c_OP_XOR = 5'h04;
  localparam logic [4:0] c_OP_CMP = 5'h05;
  localparam logic [4:0] c_OP_MOV = 5'h06;
  localparam logic [4:0] c_OP_LSH = 5'h07;
  localparam logic [4:0] c_OP_RSH = 5'h08;
  localparam int         c_SHW    = $clog2(P_WIDTH);

  logic [P_WIDTH:0] w_sum;
  logic [P_WIDTH:0] w_diff;
  logic             w_carry;
  logic             w_ovf;
  logic             w_low;
  logic             w_zero;
  logic             w_neg;

  assign w_sum  = {1'b0, I_A} + {1'b0, I_B};
  assign w_diff = {1'b0, I_A} - {1'b0, I_B};

  // Status layout: {N, Z, L, F, C}. CMP reports relations, not the result.
  always_comb begin
    O_C      = '0;
    O_STATUS = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    w_low    = 1'b0;
    w_zero   = 1'b0;
    w_neg    = 1'b0;
    if (I_ENABLE) begin
      case (I_OPCODE)
        c_OP_ADD: begin
          O_C     = w_sum[P_WIDTH-1:0];
          w_carry = w_sum[P_WIDTH];
          w_ovf   = (I_A[P_WIDTH-1] == I_B[P_WIDTH-1]) &&
                    (w_sum[P_WIDTH-1] != I_A[P_WIDTH-1]);
        end
        c_OP_SUB: begin
          O_C     = w_diff[P_WIDTH-1:0];
          w_carry = w_diff[P_WIDTH];
          w_ovf   = (I_A[P_WIDTH-1] != I_B[P_WIDTH-1]) &&
                    (w_diff[P_WIDTH-1] != I_A[P_WIDTH-1]);
        end
        c_OP_AND: O_C = I_A & I_B;
        c_OP_OR:  O_C = I_A | I_B;
        c_OP_XOR: O_C = I_A ^ I_B;
        c_OP_MOV: O_C = I_B;
        c_OP_LSH: O_C = I_A << I_B[c_SHW-1:0];
        c_OP_RSH: O_C = I_A >> I_B[c_SHW-1:0];
        default:  O_C = '0;
      endcase

      w_zero = (O_C == '0);
      w_neg  = O_C[P_WIDTH-1];
      if (I_OPCODE == c_OP_CMP) begin
        w_low  = I_A < I_B;
        w_zero = I_A == I_B;
        w_neg  = $signed(I_A) < $signed(I_B);
      end

      if (I_OPCODE <= c_OP_RSH) begin
        O_STATUS = {w_neg, w_zero, w_low, w_ovf, w_carry};
      end
    end
  end

endmodule

module cr16_alu_arbiter #(
  parameter int P_WIDTH = 16
) (
  input  logic               I_CLK,
  input  logic               I_RST,
  input  logic               I_REQ_VALID_0,
  input  logic [4:0]         I_REQ_OPCODE_0,
  input  logic [P_WIDTH-1:0] I_REQ_A_0,
  input  logic [P_WIDTH-1:0] I_REQ_B_0,
  output logic               O_REQ_READY_0,
  input  logic               I_REQ_VALID_1,
  input  logic [4:0]         I_REQ_OPCODE_1,
  input  logic [P_WIDTH-1:0] I_REQ_A_1,
  input  logic [P_WIDTH-1:0] I_REQ_B_1,
  output logic               O_REQ_READY_1,
  output logic               O_RSP_VALID_0,
  output logic               O_RSP_VALID_1,
  input  logic               I_RSP_READY_0,
  input  logic               I_RSP_READY_1,
  output logic [P_WIDTH-1:0] O_RSP_C,
  output logic [4:0]         O_RSP_STATUS,
  output logic               O_BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_ptr;
  logic               r_owner;
  logic [4:0]         r_opcode;
  logic [P_WIDTH-1:0] r_a;
  logic [P_WIDTH-1:0] r_b;

  logic               w_grant;
  logic               w_sel;
  logic               w_rsp_ready;
  logic               w_alu_en;
  logic [P_WIDTH-1:0] w_alu_c;
  logic [4:0]         w_alu_status;

  cr16_alu #(
    .P_WIDTH (P_WIDTH)
  ) u_alu (
    .I_ENABLE (w_alu_en),
    .I_OPCODE (r_opcode),
    .I_A      (r_a),
    .I_B      (r_b),
    .O_C      (w_alu_c),
    .O_STATUS (w_alu_status)
  );

  assign w_alu_en    = (r_state == ST_EXEC);
  assign w_rsp_ready = r_owner ? I_RSP_READY_1 : I_RSP_READY_0;

  always_comb begin
    w_grant       = 1'b0;
    w_sel         = 1'b0;
    w_next_state  = ST_IDLE;
    O_REQ_READY_0 = 1'b0;
    O_REQ_READY_1 = 1'b0;
    O_RSP_VALID_0 = 1'b0;
    O_RSP_VALID_1 = 1'b0;
    O_BUSY        = (r_state != ST_IDLE);

    // Ties go to the pointer; a lone requester always wins.
    if (I_REQ_VALID_0 && I_REQ_VALID_1) begin
      w_grant = 1'b1;
      w_sel   = r_ptr;
    end else if (I_REQ_VALID_0) begin
      w_grant = 1'b1;
      w_sel   = 1'b0;
    end else if (I_REQ_VALID_1) begin
      w_grant = 1'b1;
      w_sel   = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        O_REQ_READY_0 = I_REQ_VALID_0 && !w_sel;
        O_REQ_READY_1 = I_REQ_VALID_1 && w_sel;
        w_next_state  = w_grant ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: begin
        O_RSP_VALID_0 = !r_owner;
        O_RSP_VALID_1 = r_owner;
        w_next_state  = w_rsp_ready ? ST_IDLE : ST_RESP;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 1'b0;
      r_owner      <= 1'b0;
      r_opcode     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      O_RSP_C      <= '0;
      O_RSP_STATUS <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == ST_IDLE) && w_grant) begin
        r_owner  <= w_sel;
        r_ptr    <= ~w_sel;
        r_opcode <= w_sel ? I_REQ_OPCODE_1 : I_REQ_OPCODE_0;
        r_a      <= w_sel ? I_REQ_A_1 : I_REQ_A_0;
        r_b      <= w_sel ? I_REQ_B_1 : I_REQ_B_0;
      end
      if (r_state == ST_EXEC) begin
        O_RSP_C      <= w_alu_c;
        O_RSP_STATUS <= w_alu_status;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cr16_alu_arbiter.sv
// ============================================================================
// Module   : tb_cr16_alu_arbiter
// Purpose  : Self-checking bench: vector table, corner sequences, random txns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cr16_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_valid_1;
  logic [4:0]  req_opcode_0, req_opcode_1;
  logic [15:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic        req_ready_0, req_ready_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [15:0] rsp_c;
  logic [4:0]  rsp_status;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int last_served = -1;

  always #5 clk = ~clk;

  cr16_alu_arbiter #(.P_WIDTH(16)) dut (
    .I_CLK          (clk),
    .I_RST          (rst),
    .I_REQ_VALID_0  (req_valid_0),
    .I_REQ_OPCODE_0 (req_opcode_0),
    .I_REQ_A_0      (req_a_0),
    .I_REQ_B_0      (req_b_0),
    .O_REQ_READY_0  (req_ready_0),
    .I_REQ_VALID_1  (req_valid_1),
    .I_REQ_OPCODE_1 (req_opcode_1),
    .I_REQ_A_1      (req_a_1),
    .I_REQ_B_1      (req_b_1),
    .O_REQ_READY_1  (req_ready_1),
    .O_RSP_VALID_0  (rsp_valid_0),
    .O_RSP_VALID_1  (rsp_valid_1),
    .I_RSP_READY_0  (rsp_ready_0),
    .I_RSP_READY_1  (rsp_ready_1),
    .O_RSP_C        (rsp_c),
    .O_RSP_STATUS   (rsp_status),
    .O_BUSY         (busy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [4:0]  st;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from the arithmetic meaning of each op; status = {N,Z,L,F,C}.
  function automatic void alu_model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] c, output logic [4:0] st);
    int ua, ub, sa, sb, r, p;
    bit cy, f;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    cy = 1'b0;
    f  = 1'b0;
    r  = 0;
    p  = 1 << b[3:0];
    case (op)
      5'd0: begin r = ua + ub; cy = (r > 65535); f = (sa + sb > 32767) || (sa + sb < -32768); end
      5'd1: begin r = ua - ub; cy = (ua < ub);   f = (sa - sb > 32767) || (sa - sb < -32768); end
      5'd2: r = int'(a & b);
      5'd3: r = int'(a | b);
      5'd4: r = int'(a ^ b);
      5'd5: begin
        c  = 16'h0000;
        st = {sa < sb, ua == ub, ua < ub, 2'b00};
        return;
      end
      5'd6: r = ub;
      5'd7: r = ua * p;
      5'd8: r = ua / p;
      default: begin
        c  = 16'h0000;
        st = 5'h00;
        return;
      end
    endcase
    c  = r[15:0];
    st = {c[15], c == 16'h0000, 1'b0, f, cy};
  endfunction

  // Tie goes to whoever was not served last; requester 0 after reset.
  function automatic int predict(input bit v0, input bit v1);
    if (v0 && v1) return (last_served == 0) ? 1 : 0;
    return v0 ? 0 : 1;
  endfunction

  task automatic idle_inputs();
    req_valid_0 = 0; req_valid_1 = 0;
    rsp_ready_0 = 0; rsp_ready_1 = 0;
  endtask

  // Starts in IDLE just after a rising edge; owner accepts after 'hold' stall cycles.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [4:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [4:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                         input int hold, input int win,
                         input logic [15:0] ec, input logic [4:0] es, input string nm);
    req_valid_0 = v0; req_opcode_0 = op0; req_a_0 = a0; req_b_0 = b0;
    req_valid_1 = v1; req_opcode_1 = op1; req_a_1 = a1; req_b_1 = b1;
    rsp_ready_0 = 0; rsp_ready_1 = 0;
    @(negedge clk);
    check({nm, ":req_ready0"}, req_ready_0, win == 0);
    check({nm, ":req_ready1"}, req_ready_1, win == 1);
    step();
    req_valid_0 = 0; req_valid_1 = 0;
    req_a_0 = 16'($urandom); req_b_0 = 16'($urandom);
    req_a_1 = 16'($urandom); req_b_1 = 16'($urandom);
    @(negedge clk);
    check({nm, ":exec_busy"}, busy, 1);
    check({nm, ":exec_rspv"}, {rsp_valid_1, rsp_valid_0}, 0);
    step();
    for (int k = 0; k <= hold; k++) begin
      req_valid_0 = 1'($urandom);
      req_valid_1 = 1'($urandom);
      rsp_ready_0 = (win == 0) ? (k == hold) : 1'b1;
      rsp_ready_1 = (win == 1) ? (k == hold) : 1'b1;
      @(negedge clk);
      check({nm, ":rsp_valid0"}, rsp_valid_0, win == 0);
      check({nm, ":rsp_valid1"}, rsp_valid_1, win == 1);
      check({nm, ":rsp_c"}, rsp_c, ec);
      check({nm, ":rsp_status"}, rsp_status, es);
      check({nm, ":no_req_ready"}, {req_ready_1, req_ready_0}, 0);
      step();
    end
    idle_inputs();
    @(negedge clk);
    check({nm, ":done_busy"}, busy, 0);
    step();
    last_served = win;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    last_served = -1;
  endtask

  task automatic check_cleared(input string nm);
    @(negedge clk);
    check({nm, ":busy"}, busy, 0);
    check({nm, ":rsp_valid"}, {rsp_valid_1, rsp_valid_0}, 0);
    check({nm, ":rsp_c"}, rsp_c, 0);
    check({nm, ":rsp_status"}, rsp_status, 0);
  endtask

  initial begin
    int gq[$];
    logic [15:0] cq[$];
    int vq[$];
    logic [15:0] ec;
    logic [4:0]  es;

    vecs[0]  = '{5'h00, 16'h0003, 16'h0004, 16'h0007, 5'h00};
    vecs[1]  = '{5'h00, 16'hFFFF, 16'h0001, 16'h0000, 5'h09};
    vecs[2]  = '{5'h00, 16'h7FFF, 16'h0001, 16'h8000, 5'h12};
    vecs[3]  = '{5'h01, 16'h0005, 16'h0007, 16'hFFFE, 5'h11};
    vecs[4]  = '{5'h02, 16'hF0F0, 16'h3C3C, 16'h3030, 5'h00};
    vecs[5]  = '{5'h03, 16'h0F00, 16'h00F0, 16'h0FF0, 5'h00};
    vecs[6]  = '{5'h04, 16'hAAAA, 16'hAAAA, 16'h0000, 5'h08};
    vecs[7]  = '{5'h05, 16'h0005, 16'h0005, 16'h0000, 5'h08};
    vecs[8]  = '{5'h05, 16'h0003, 16'h8000, 16'h0000, 5'h04};
    vecs[9]  = '{5'h05, 16'h8000, 16'h0003, 16'h0000, 5'h10};
    vecs[10] = '{5'h06, 16'h0000, 16'h1234, 16'h1234, 5'h00};
    vecs[11] = '{5'h07, 16'h0001, 16'h0004, 16'h0010, 5'h00};
    vecs[12] = '{5'h08, 16'h8000, 16'h000F, 16'h0001, 5'h00};
    vecs[13] = '{5'h1F, 16'h1234, 16'h5678, 16'h0000, 5'h00};

    req_opcode_0 = 0; req_a_0 = 0; req_b_0 = 0;
    req_opcode_1 = 0; req_a_1 = 0; req_b_1 = 0;
    do_reset();
    @(negedge clk);
    check("reset:busy", busy, 0);
    check("reset:rsp_valid", {rsp_valid_1, rsp_valid_0}, 0);
    check("reset:rsp_c", rsp_c, 0);
    check("reset:rsp_status", rsp_status, 0);
    check("reset:req_ready", {req_ready_1, req_ready_0}, 0);
    step();

    // Vector table through requester 0; the first entry is the cycle-exact solo case.
    for (int i = 0; i < 14; i++)
      run_txn(1, 0, vecs[i].op, vecs[i].a, vecs[i].b, 5'h00, 16'h0, 16'h0,
              i % 3, 0, vecs[i].c, vecs[i].st, $sformatf("vec%0d", i));

    // Continuous contention: grants and results must alternate.
    do_reset();
    req_valid_0 = 1; req_opcode_0 = 5'h00; req_a_0 = 16'h0001; req_b_0 = 16'h0001;
    req_valid_1 = 1; req_opcode_1 = 5'h00; req_a_1 = 16'h0010; req_b_1 = 16'h0010;
    rsp_ready_0 = 1; rsp_ready_1 = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (req_ready_0) gq.push_back(0);
      if (req_ready_1) gq.push_back(1);
      if (rsp_valid_0 || rsp_valid_1) begin
        cq.push_back(rsp_c);
        vq.push_back(rsp_valid_1 ? 1 : 0);
      end
      step();
    end
    idle_inputs();
    step();
    last_served = 1;
    check("contend:grant_count", gq.size(), 4);
    check("contend:rsp_count", cq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size() && i < cq.size(); i++) begin
      check($sformatf("contend:grant%0d", i), gq[i], i % 2);
      check($sformatf("contend:c%0d", i), cq[i], (i % 2) ? 16'h0020 : 16'h0002);
      check($sformatf("contend:owner%0d", i), vq[i], i % 2);
    end

    // Backpressure on requester 1, then a tie must go to requester 0.
    alu_model(5'h01, 16'h0100, 16'h0001, ec, es);
    run_txn(0, 1, 5'h00, 16'h0, 16'h0, 5'h01, 16'h0100, 16'h0001, 5, 1, ec, es, "bp");
    alu_model(5'h00, 16'h0002, 16'h0003, ec, es);
    run_txn(1, 1, 5'h00, 16'h0002, 16'h0003, 5'h04, 16'h1111, 16'h2222,
            0, predict(1, 1), ec, es, "fair");
    check("fair:model_winner", last_served, 0);

    // Reset during EXEC after a solo grant to 0 (which pointed the tie at 1).
    req_valid_0 = 1; req_opcode_0 = 5'h00; req_a_0 = 16'h0001; req_b_0 = 16'h0001;
    step();
    req_valid_0 = 0;
    rst = 1;
    step();
    rst = 0;
    last_served = -1;
    check_cleared("rst_exec");
    step();
    alu_model(5'h00, 16'h0009, 16'h0001, ec, es);
    run_txn(1, 1, 5'h00, 16'h0009, 16'h0001, 5'h00, 16'h0, 16'h1, 0, 0, ec, es, "rst_exec_tie");

    // Reset during RESP with the response still pending.
    req_valid_0 = 1; req_opcode_0 = 5'h00; req_a_0 = 16'h0002; req_b_0 = 16'h0002;
    step();
    req_valid_0 = 0;
    step();
    @(negedge clk);
    check("rst_resp:pre_valid", rsp_valid_0, 1);
    check("rst_resp:pre_c", rsp_c, 16'h0004);
    rst = 1;
    step();
    rst = 0;
    last_served = -1;
    check_cleared("rst_resp");
    step();
    alu_model(5'h03, 16'h00F0, 16'h0F00, ec, es);
    run_txn(1, 1, 5'h03, 16'h00F0, 16'h0F00, 5'h00, 16'h0, 16'h1, 0, 0, ec, es, "rst_resp_tie");

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      bit v0, v1;
      int w;
      logic [4:0]  o0, o1;
      logic [15:0] a0, b0, a1, b1;
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      o0 = 5'($urandom_range(0, 9)); o1 = 5'($urandom_range(0, 9));
      a0 = 16'($urandom); b0 = 16'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom);
      w = predict(v0, v1);
      if (w == 0) alu_model(o0, a0, b0, ec, es);
      else        alu_model(o1, a1, b1, ec, es);
      run_txn(v0, v1, o0, a0, b0, o1, a1, b1, $urandom_range(0, 3), w, ec, es,
              $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cr16_alu_arbiter.md
Name: cr16_alu_arbiter

Overview:
- Shares one cr16_alu instance between two requesters (for example, the CR16 datapath and a debug/test port) using valid/ready handshakes and round-robin arbitration.
- Operands and opcode are latched at grant, the ALU is enabled for exactly one execute cycle, and C and status are registered.
- The result is held on a shared response bus until the owning requester accepts it.
- Sits between the requesters and the cr16_alu; it replaces the hand-stepped operand-loading front end for clocked use.

Parameters:
- P_WIDTH, 16, operand/result width; passed to cr16_alu P_WIDTH.

Ports:
- I_CLK  input  1  system clock; all state updates on rising edge.
- I_RST  input  1  synchronous, active-high reset.
- I_REQ_VALID_0  input  1  requester 0 has a request.
- I_REQ_OPCODE_0  input  5  requester 0 ALU opcode.
- I_REQ_A_0  input  P_WIDTH  requester 0 operand A.
- I_REQ_B_0  input  P_WIDTH  requester 0 operand B.
- O_REQ_READY_0  output  1  request 0 accepted this cycle.
- I_REQ_VALID_1, I_REQ_OPCODE_1, I_REQ_A_1, I_REQ_B_1, O_REQ_READY_1: same as the _0 ports, for requester 1.
- O_RSP_VALID_0  output  1  response on the shared bus belongs to requester 0.
- O_RSP_VALID_1  output  1  response on the shared bus belongs to requester 1.
- I_RSP_READY_0  input  1  requester 0 consumes the response.
- I_RSP_READY_1  input  1  requester 1 consumes the response.
- O_RSP_C  output  P_WIDTH  registered ALU result.
- O_RSP_STATUS  output  5  registered ALU status flags.
- O_BUSY  output  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. State is 2-bit; unused encodings go to IDLE.
- Reset (I_RST=1 at a clock edge), taking priority over everything, including mid-EXEC or mid-RESP:
  - state=IDLE and priority pointer ptr=0;
  - latched opcode, A, B, O_RSP_C, O_RSP_STATUS and owner all 0;
  - O_RSP_VALID_0 and O_RSP_VALID_1 = 0 and O_BUSY=0;
  - any in-flight response is discarded.
- Grant selection (combinational, IDLE only):
  - both valid: sel = ptr;
  - only one valid: sel = that requester;
  - neither valid: no grant.
- O_REQ_READY_n = (state==IDLE) && I_REQ_VALID_n && (sel==n). At most one ready is high per cycle; both are 0 outside IDLE.
- Handshake on VALID_n && READY_n at edge N:
  - latch opcode/A/B of requester n and set owner=n;
  - set ptr = ~n;
  - state becomes EXEC.
- EXEC (cycle N+1):
  - cr16_alu I_ENABLE=1 with the latched operands;
  - at the edge, capture C into O_RSP_C and status into O_RSP_STATUS;
  - state becomes RESP.
  - I_ENABLE=0 in every other state.
- RESP (from cycle N+2):
  - O_RSP_VALID_owner=1; the other response valid is 0;
  - O_RSP_C and O_RSP_STATUS stay stable while valid;
  - when I_RSP_READY_owner=1, go to IDLE at that edge; I_RSP_READY of the non-owner is ignored.
- Minimum request-to-response latency: 2 cycles. Minimum issue interval: 3 cycles (no back-to-back acceptance; a new grant is possible in the cycle after the response handshake).
- Request inputs are ignored outside IDLE. A requester may drop VALID before its handshake with no effect.
- Round-robin: under continuous contention, grants alternate 0,1,0,1. After a solo grant to n, ptr=~n, so the other requester wins the next tie.
- Width rules: opcode is always 5 bits; the ALU status width is 5; no width conversion in this block.

Test Plan:
- Reset then solo request: I_REQ_VALID_0=1, ADD, A=0x0003, B=0x0004.
  - Required: READY_0 high in cycle 0.
  - O_RSP_VALID_0=1 with O_RSP_C=0x0007 at cycle 2.
  - With I_RSP_READY_0=1, O_BUSY=0 at cycle 3.
- Contention: both valid continuously after reset, each with a distinct op (req0 ADD 0x0001+0x0001, req1 ADD 0x0010+0x0010).
  - Required: grants alternate 0,1,0,1.
  - O_RSP_C sequence is 0x0002, 0x0020, 0x0002, 0x0020, with matching O_RSP_VALID_n.
- Response backpressure: hold I_RSP_READY_1=0 for 5 cycles in RESP.
  - Required: O_RSP_VALID_1, O_RSP_C and O_RSP_STATUS stay stable and no READY is asserted.
  - Asserting I_RSP_READY_0 (non-owner) has no effect.
- Reset mid-operation: assert I_RST during EXEC, and separately during RESP.
  - Required: next cycle state=IDLE, both response valids 0, O_RSP_C=0, ptr=0.
  - The subsequent contended grant goes to requester 0.
- Fairness after a solo grant: a solo req1, then both valid.
  - Required: requester 0 wins the tie.
- Status passthrough: an opcode/operand pair that sets a known cr16_alu flag (e.g. compare 0x0005 vs 0x0005).
  - Required: O_RSP_STATUS equals the cr16_alu O_STATUS for that op, captured at EXEC.
